// File: rtl/channel_sram_sequencer_if.sv
// Read-requester port of channel_sram_sequencer.
//   rd_req   : requester -> sequencer, level request; rd_addr held until rd_ack
//   rd_addr  : requester -> sequencer, SRAM word address to read
//   rd_ack   : sequencer -> requester, one-cycle pulse, address accepted
//   rd_valid : sequencer -> requester, one-cycle pulse, rd_data valid
//   rd_data  : sequencer -> requester, registered read word
interface channel_sram_sequencer_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [15:0]       rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/channel_sram_sequencer.sv
// Captures six 8-bit channel samples into an external asynchronous SRAM as
// atomic three-word write bursts, and interleaves single-word reads for one
// read requester between bursts. A full frame of 2**IDX_W samples raises
// frame_done until the next capture_start.
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   channel1..6_analog        : sample values, latched on new_sample
//   new_sample, capture_start : one-cycle strobes (capture / rearm frame)
//   write_index, frame_done, overrun : frame status
//   rd                        : read-requester port (slave side)
//   sram_*                    : SRAM pins, all controls registered
module channel_sram_sequencer #(
  parameter int unsigned IDX_W     = 12,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [7:0]             channel1_analog,
  input  logic [7:0]             channel2_analog,
  input  logic [7:0]             channel3_analog,
  input  logic [7:0]             channel4_analog,
  input  logic [7:0]             channel5_analog,
  input  logic [7:0]             channel6_analog,
  input  logic                   new_sample,
  input  logic                   capture_start,
  output logic [IDX_W-1:0]       write_index,
  output logic                   frame_done,
  output logic                   overrun,
  channel_sram_sequencer_if.slave rd,
  inout  wire  [15:0]            sram_DQ,
  output logic [ADDR_W-1:0]      sram_ADDR,
  output logic                   sram_LB_N,
  output logic                   sram_UB_N,
  output logic                   sram_CE_N,
  output logic                   sram_OE_N,
  output logic                   sram_WE_N
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] W_SET = 3'd1;
  localparam logic [2:0] W_HLD = 3'd2;
  localparam logic [2:0] R_ADR = 3'd3;
  localparam logic [2:0] R_CAP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              pend_q, pend_d;
  logic              armed_q, armed_d;
  logic              start_pend_q, start_pend_d;
  logic              last_write_q, last_write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [47:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_q, dq_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] slot_base;

  assign slot_base = ADDR_W'(BASE_ADDR) + ADDR_W'({idx_q, 2'b00});

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    pend_d       = pend_q;
    armed_d      = armed_q;
    start_pend_d = start_pend_q | capture_start;
    last_write_d = last_write_q;
    idx_d        = idx_q;
    done_d       = done_q;
    ovr_d        = ovr_q;
    hold_d       = hold_q;
    addr_d       = addr_q;

    // A strobe coinciding with capture_start is dropped: the rearm wins.
    if (new_sample && armed_q && !capture_start) begin
      if (pend_q) begin
        ovr_d = 1'b1;
      end else begin
        hold_d = {channel6_analog, channel5_analog, channel4_analog,
                  channel3_analog, channel2_analog, channel1_analog};
        pend_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_pend_q) begin
          // A fresh pulse arriving in this very cycle stays latched.
          start_pend_d = capture_start;
          idx_d        = '0;
          done_d       = 1'b0;
          ovr_d        = 1'b0;
          armed_d      = 1'b1;
          pend_d       = 1'b0;
        end
        // After a burst, one waiting read goes first (last_write).
        if (pend_q && !start_pend_q && !(last_write_q && rd.rd_req)) begin
          state_d = W_SET;
          k_d     = 2'd0;
          addr_d  = slot_base;
        end else if (rd.rd_req) begin
          state_d = R_ADR;
          addr_d  = rd.rd_addr;
        end
      end
      W_SET: state_d = W_HLD;
      W_HLD: begin
        if (k_q != 2'd2) begin
          k_d     = k_q + 2'd1;
          state_d = W_SET;
          addr_d  = slot_base + ADDR_W'(k_q + 2'd1);
        end else begin
          pend_d       = 1'b0;
          last_write_d = 1'b1;
          state_d      = IDLE;
          if (idx_q == '1) begin
            idx_d   = '0;
            done_d  = 1'b1;
            armed_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      R_ADR: state_d = R_CAP;
      R_CAP: begin
        last_write_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pin controls are registered from the next state so they change
    // exactly on state entry and never glitch.
    ce_n_d  = (state_d == IDLE);
    we_n_d  = (state_d != W_SET);
    oe_n_d  = !((state_d == R_ADR) || (state_d == R_CAP));
    dq_oe_d = (state_d == W_SET) || (state_d == W_HLD);
    case (k_d)
      2'd0:    dq_d = hold_q[15:0];
      2'd1:    dq_d = hold_q[31:16];
      default: dq_d = hold_q[47:32];
    endcase
    rd_ack_d   = (state_d == R_ADR);
    rd_valid_d = (state_q == R_CAP);
    rd_data_d  = (state_q == R_CAP) ? sram_DQ : rd_data_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      pend_q       <= 1'b0;
      armed_q      <= 1'b0;
      start_pend_q <= 1'b0;
      last_write_q <= 1'b0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      hold_q       <= '0;
      addr_q       <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      dq_q         <= '0;
      rd_ack_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pend_q       <= pend_d;
      armed_q      <= armed_d;
      start_pend_q <= start_pend_d;
      last_write_q <= last_write_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
      hold_q       <= hold_d;
      addr_q       <= addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dq_oe_q      <= dq_oe_d;
      dq_q         <= dq_d;
      rd_ack_q     <= rd_ack_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign write_index = idx_q;
  assign frame_done  = done_q;
  assign overrun     = ovr_q;
  assign rd.rd_ack   = rd_ack_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign sram_ADDR   = addr_q;
  assign sram_CE_N   = ce_n_q;
  assign sram_OE_N   = oe_n_q;
  assign sram_WE_N   = we_n_q;
  assign sram_LB_N   = ce_n_q;
  assign sram_UB_N   = ce_n_q;
  assign sram_DQ     = dq_oe_q ? dq_q : 'z;

endmodule
